// File: rtl/if_id_stage.sv
// Fetch/decode stage of the 3-stage RV32I pipeline: picks the fetched word, decodes it
// into registered execute controls and holds the architectural register file.
module if_id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        inst_mem_is_valid,
  input  logic [31:0] inst_mem_read_data,
  input  logic        stall_read_i,
  input  logic [31:0] inst_fetch_pc,
  input  logic [31:0] instruction_i,
  input  logic        wb_stall,
  input  logic        wb_alu_to_reg,
  input  logic        wb_mem_to_reg,
  input  logic [4:0]  wb_dest_reg_sel,
  input  logic [31:0] wb_result,
  input  logic [31:0] wb_read_data,
  input  logic [1:0]  inst_mem_offset,
  output logic        exception,
  output logic [31:0] execute_immediate_w,
  output logic        immediate_sel_w,
  output logic        alu_w,
  output logic        lui_w,
  output logic        jal_w,
  output logic        jalr_w,
  output logic        branch_w,
  output logic        mem_write_w,
  output logic        mem_to_reg_w,
  output logic        arithsubtype_w,
  output logic [31:0] pc_w,
  output logic [4:0]  src1_select_w,
  output logic [4:0]  src2_select_w,
  output logic [4:0]  dest_reg_sel_w,
  output logic [2:0]  alu_operation_w,
  output logic        illegal_inst_w,
  output logic [31:0] instruction_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [31:0] inst;
  logic        bubble;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign inst   = stall_read_i ? instruction_i : inst_mem_read_data;
  assign bubble = !inst_mem_is_valid || (inst_mem_offset != 2'b00);
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  logic [31:0] dec_imm;
  logic        dec_imm_sel, dec_alu, dec_lui, dec_jal, dec_jalr, dec_branch;
  logic        dec_mem_write, dec_mem_to_reg, dec_arithsub, dec_illegal;
  logic [4:0]  dec_src1, dec_src2, dec_dest;
  logic [2:0]  dec_aluop;

  always_comb begin
    dec_imm        = '0;
    dec_imm_sel    = 1'b0;
    dec_alu        = 1'b0;
    dec_lui        = 1'b0;
    dec_jal        = 1'b0;
    dec_jalr       = 1'b0;
    dec_branch     = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_arithsub   = 1'b0;
    dec_illegal    = 1'b0;
    dec_src1       = '0;
    dec_src2       = '0;
    dec_dest       = '0;
    dec_aluop      = '0;
    case (opcode)
      OP_LUI: begin
        dec_lui = 1'b1; dec_imm_sel = 1'b1; dec_imm = imm_u; dec_dest = inst[11:7];
      end
      OP_AUIPC: begin
        dec_lui = 1'b1; dec_imm_sel = 1'b1; dec_dest = inst[11:7];
        dec_imm = inst_fetch_pc + imm_u;
      end
      OP_JAL: begin
        dec_jal = 1'b1; dec_imm = imm_j; dec_dest = inst[11:7];
      end
      OP_JALR: begin
        dec_jalr = 1'b1; dec_imm_sel = 1'b1; dec_imm = imm_i;
        dec_src1 = inst[19:15]; dec_dest = inst[11:7];
        dec_illegal = (funct3 != 3'b000);
      end
      OP_BRANCH: begin
        dec_branch = 1'b1; dec_imm = imm_b; dec_aluop = funct3;
        dec_src1 = inst[19:15]; dec_src2 = inst[24:20];
        dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_LOAD: begin
        dec_mem_to_reg = 1'b1; dec_imm_sel = 1'b1; dec_imm = imm_i; dec_aluop = funct3;
        dec_src1 = inst[19:15]; dec_dest = inst[11:7];
        dec_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        dec_mem_write = 1'b1; dec_imm_sel = 1'b1; dec_imm = imm_s; dec_aluop = funct3;
        dec_src1 = inst[19:15]; dec_src2 = inst[24:20];
        dec_illegal = (funct3 >= 3'b011);
      end
      OP_IMM: begin
        dec_alu = 1'b1; dec_imm_sel = 1'b1; dec_imm = imm_i; dec_aluop = funct3;
        dec_src1 = inst[19:15]; dec_dest = inst[11:7];
        dec_arithsub = (funct3 == 3'b101) && inst[30];
        // Shift-immediates reuse the upper I-immediate bits as funct7.
        if (funct3 == 3'b001)
          dec_illegal = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          dec_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OP_REG: begin
        dec_alu = 1'b1; dec_aluop = funct3; dec_arithsub = inst[30];
        dec_src1 = inst[19:15]; dec_src2 = inst[24:20]; dec_dest = inst[11:7];
        dec_illegal = !((funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OP_FENCE, OP_SYSTEM: begin
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_imm        = '0;
      dec_imm_sel    = 1'b0;
      dec_alu        = 1'b0;
      dec_lui        = 1'b0;
      dec_jal        = 1'b0;
      dec_jalr       = 1'b0;
      dec_branch     = 1'b0;
      dec_mem_write  = 1'b0;
      dec_mem_to_reg = 1'b0;
      dec_arithsub   = 1'b0;
      dec_src1       = '0;
      dec_src2       = '0;
      dec_dest       = '0;
      dec_aluop      = '0;
    end
  end

  // Control bundle order: illegal, imm_sel, alu, lui, jal, jalr, branch, mem_write, mem_to_reg, arithsub.
  logic [9:0]  ctrl_q, ctrl_d, dec_ctrl;
  logic [31:0] imm_q, imm_d, pc_q, pc_d, inst_q, inst_d;
  logic [14:0] sel_q, sel_d;
  logic [2:0]  aluop_q, aluop_d;
  logic        exc_q, exc_d;

  assign dec_ctrl = {dec_illegal, dec_imm_sel, dec_alu, dec_lui, dec_jal, dec_jalr,
                     dec_branch, dec_mem_write, dec_mem_to_reg, dec_arithsub};

  always_comb begin
    ctrl_d  = ctrl_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    sel_d   = sel_q;
    aluop_d = aluop_q;
    if (!stall) begin
      pc_d = inst_fetch_pc;
      if (bubble) begin
        ctrl_d  = '0;
        imm_d   = '0;
        inst_d  = NOP;
        sel_d   = '0;
        aluop_d = '0;
      end else begin
        ctrl_d  = dec_ctrl;
        imm_d   = dec_imm;
        inst_d  = inst;
        sel_d   = {dec_src1, dec_src2, dec_dest};
        aluop_d = dec_aluop;
      end
    end
    // Misaligned fetches fault even while stalled; illegal words fault when they are loaded.
    exc_d = exc_q
          || (inst_mem_is_valid && (inst_mem_offset != 2'b00))
          || (!stall && !bubble && dec_illegal);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      inst_q  <= NOP;
      sel_q   <= '0;
      aluop_q <= '0;
      exc_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      sel_q   <= sel_d;
      aluop_q <= aluop_d;
      exc_q   <= exc_d;
    end
  end

  assign {illegal_inst_w, immediate_sel_w, alu_w, lui_w, jal_w, jalr_w,
          branch_w, mem_write_w, mem_to_reg_w, arithsubtype_w} = ctrl_q;
  assign {src1_select_w, src2_select_w, dest_reg_sel_w} = sel_q;
  assign execute_immediate_w = imm_q;
  assign pc_w                = pc_q;
  assign instruction_o       = inst_q;
  assign alu_operation_w     = aluop_q;
  assign exception           = exc_q;

  // Register file; x0 is never written so it always reads zero.
  logic [31:0] regs [0:31];
  logic        wb_we;
  logic [31:0] wb_data;

  assign wb_we   = !wb_stall && (wb_alu_to_reg || wb_mem_to_reg) && (wb_dest_reg_sel != 5'd0);
  assign wb_data = wb_mem_to_reg ? wb_read_data : wb_result;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (reset)
        regs[i] <= '0;
      else if (wb_we && (wb_dest_reg_sel == i[4:0]))
        regs[i] <= wb_data;
      else
        regs[i] <= regs[i];
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: decode classes, stall/bubble, exception stickiness, writeback.
module tb_if_id_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        inst_mem_is_valid;
  logic [31:0] inst_mem_read_data;
  logic        stall_read_i;
  logic [31:0] inst_fetch_pc;
  logic [31:0] instruction_i;
  logic        wb_stall;
  logic        wb_alu_to_reg;
  logic        wb_mem_to_reg;
  logic [4:0]  wb_dest_reg_sel;
  logic [31:0] wb_result;
  logic [31:0] wb_read_data;
  logic [1:0]  inst_mem_offset;
  logic        exception;
  logic [31:0] execute_immediate_w;
  logic        immediate_sel_w, alu_w, lui_w, jal_w, jalr_w, branch_w;
  logic        mem_write_w, mem_to_reg_w, arithsubtype_w, illegal_inst_w;
  logic [31:0] pc_w;
  logic [4:0]  src1_select_w, src2_select_w, dest_reg_sel_w;
  logic [2:0]  alu_operation_w;
  logic [31:0] instruction_o;

  int errors = 0;
  int checks = 0;

  if_id_stage dut (
    .clk                (clk),
    .reset              (reset),
    .stall              (stall),
    .inst_mem_is_valid  (inst_mem_is_valid),
    .inst_mem_read_data (inst_mem_read_data),
    .stall_read_i       (stall_read_i),
    .inst_fetch_pc      (inst_fetch_pc),
    .instruction_i      (instruction_i),
    .wb_stall           (wb_stall),
    .wb_alu_to_reg      (wb_alu_to_reg),
    .wb_mem_to_reg      (wb_mem_to_reg),
    .wb_dest_reg_sel    (wb_dest_reg_sel),
    .wb_result          (wb_result),
    .wb_read_data       (wb_read_data),
    .inst_mem_offset    (inst_mem_offset),
    .exception          (exception),
    .execute_immediate_w(execute_immediate_w),
    .immediate_sel_w    (immediate_sel_w),
    .alu_w              (alu_w),
    .lui_w              (lui_w),
    .jal_w              (jal_w),
    .jalr_w             (jalr_w),
    .branch_w           (branch_w),
    .mem_write_w        (mem_write_w),
    .mem_to_reg_w       (mem_to_reg_w),
    .arithsubtype_w     (arithsubtype_w),
    .pc_w               (pc_w),
    .src1_select_w      (src1_select_w),
    .src2_select_w      (src2_select_w),
    .dest_reg_sel_w     (dest_reg_sel_w),
    .alu_operation_w    (alu_operation_w),
    .illegal_inst_w     (illegal_inst_w),
    .instruction_o      (instruction_o)
  );

  // Packed views: {illegal, imm_sel, alu, lui, jal, jalr, branch, mem_write, mem_to_reg, arithsub}
  logic [9:0]  ctrl;
  logic [14:0] sel;
  assign ctrl = {illegal_inst_w, immediate_sel_w, alu_w, lui_w, jal_w, jalr_w,
                 branch_w, mem_write_w, mem_to_reg_w, arithsubtype_w};
  assign sel  = {src1_select_w, src2_select_w, dest_reg_sel_w};

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] word, input logic [31:0] pc);
    inst_mem_read_data = word;
    inst_fetch_pc      = pc;
    inst_mem_is_valid  = 1'b1;
    inst_mem_offset    = 2'b00;
    stall_read_i       = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inst_mem_is_valid = 1'b1;
    inst_mem_read_data = 32'h0000_0000;
    tick();
    tick();
    checks++; if (ctrl !== 10'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, 10'b0); end
    checks++; if (instruction_o !== 32'h13) begin errors++; $display("FAIL reset_inst got=%h exp=%h", instruction_o, 32'h13); end
    checks++; if ({exception, execute_immediate_w, pc_w, sel, alu_operation_w} !== '0) begin
      errors++; $display("FAIL reset_misc exc=%b imm=%h pc=%h sel=%h op=%0d exp all zero",
                         exception, execute_immediate_w, pc_w, sel, alu_operation_w);
    end
    checks++; if (dut.regs[5] !== 32'h0) begin errors++; $display("FAIL reset_regs got=%h exp=0", dut.regs[5]); end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    fetch(32'h0050_0093, 32'h0);  // ADDI x1,x0,5
    checks++; if (ctrl !== 10'b0110000000) begin errors++; $display("FAIL addi_ctrl got=%b exp=%b", ctrl, 10'b0110000000); end
    checks++; if (execute_immediate_w !== 32'd5) begin errors++; $display("FAIL addi_imm got=%h exp=5", execute_immediate_w); end
    checks++; if (sel !== {5'd0, 5'd0, 5'd1}) begin errors++; $display("FAIL addi_sel got=%h exp=%h", sel, {5'd0, 5'd0, 5'd1}); end
    checks++; if ({alu_operation_w, pc_w} !== {3'b000, 32'h0}) begin errors++; $display("FAIL addi_op_pc op=%0d pc=%h exp 0/0", alu_operation_w, pc_w); end
    fetch(32'h4020_81B3, 32'h4);  // SUB x3,x1,x2
    checks++; if (ctrl !== 10'b0010000001) begin errors++; $display("FAIL sub_ctrl got=%b exp=%b", ctrl, 10'b0010000001); end
    checks++; if (sel !== {5'd1, 5'd2, 5'd3}) begin errors++; $display("FAIL sub_sel got=%h exp=%h", sel, {5'd1, 5'd2, 5'd3}); end
    checks++; if (instruction_o !== 32'h4020_81B3) begin errors++; $display("FAIL sub_inst got=%h exp=402081b3", instruction_o); end
    fetch(32'h4030_D093, 32'h8);  // SRAI x1,x1,3
    checks++; if (ctrl !== 10'b0110000001) begin errors++; $display("FAIL srai_ctrl got=%b exp=%b", ctrl, 10'b0110000001); end
    checks++; if ({alu_operation_w, execute_immediate_w} !== {3'b101, 32'h403}) begin
      errors++; $display("FAIL srai_op_imm op=%0d imm=%h exp 5/403", alu_operation_w, execute_immediate_w);
    end
  endtask

  task automatic test_branch_store();
    fetch(32'h0011_2223, 32'h10);  // SW x1,4(x2)
    checks++; if (ctrl !== 10'b0100000100) begin errors++; $display("FAIL sw_ctrl got=%b exp=%b", ctrl, 10'b0100000100); end
    checks++; if ({sel, alu_operation_w, execute_immediate_w} !== {5'd2, 5'd1, 5'd0, 3'b010, 32'd4}) begin
      errors++; $display("FAIL sw_fields sel=%h op=%0d imm=%h exp sel=%h op=2 imm=4", sel, alu_operation_w, execute_immediate_w, {5'd2, 5'd1, 5'd0});
    end
    fetch(32'hFE00_0EE3, 32'h14);  // BEQ x0,x0,-4
    checks++; if (ctrl !== 10'b0000001000) begin errors++; $display("FAIL beq_ctrl got=%b exp=%b", ctrl, 10'b0000001000); end
    checks++; if (execute_immediate_w !== 32'hFFFF_FFFC) begin errors++; $display("FAIL beq_imm got=%h exp=fffffffc", execute_immediate_w); end
    checks++; if ({dest_reg_sel_w, pc_w} !== {5'd0, 32'h14}) begin errors++; $display("FAIL beq_dest_pc dest=%0d pc=%h exp 0/14", dest_reg_sel_w, pc_w); end
  endtask

  task automatic test_stall_bubble();
    stall = 1'b1;
    fetch(32'h1234_52B7, 32'h18);  // LUI while stalled: must not load
    checks++; if ({ctrl, execute_immediate_w, pc_w} !== {10'b0000001000, 32'hFFFF_FFFC, 32'h14}) begin
      errors++; $display("FAIL stall_hold ctrl=%b imm=%h pc=%h exp branch/fffffffc/14", ctrl, execute_immediate_w, pc_w);
    end
    stall = 1'b0;
    tick();
    checks++; if ({ctrl, execute_immediate_w, dest_reg_sel_w} !== {10'b0101000000, 32'h1234_5000, 5'd5}) begin
      errors++; $display("FAIL lui ctrl=%b imm=%h dest=%0d exp lui/12345000/5", ctrl, execute_immediate_w, dest_reg_sel_w);
    end
    inst_mem_is_valid = 1'b0;
    inst_fetch_pc     = 32'h1C;
    tick();
    checks++; if ({ctrl, sel, execute_immediate_w} !== '0) begin
      errors++; $display("FAIL bubble_ctrl ctrl=%b sel=%h imm=%h exp zeros", ctrl, sel, execute_immediate_w);
    end
    checks++; if ({instruction_o, pc_w} !== {32'h13, 32'h1C}) begin
      errors++; $display("FAIL bubble_inst_pc inst=%h pc=%h exp 13/1c", instruction_o, pc_w);
    end
    checks++; if (exception !== 1'b0) begin errors++; $display("FAIL bubble_noexc got=%b exp=0", exception); end
  endtask

  task automatic test_upper_replay();
    fetch(32'h0000_1117, 32'h100);  // AUIPC x2,1 -> pc + 0x1000
    checks++; if ({ctrl, execute_immediate_w, dest_reg_sel_w} !== {10'b0101000000, 32'h1100, 5'd2}) begin
      errors++; $display("FAIL auipc ctrl=%b imm=%h dest=%0d exp lui/1100/2", ctrl, execute_immediate_w, dest_reg_sel_w);
    end
    inst_mem_read_data = 32'h0000_0000;
    instruction_i      = 32'h0050_0093;
    stall_read_i       = 1'b1;
    tick();
    checks++; if ({ctrl, execute_immediate_w, instruction_o} !== {10'b0110000000, 32'd5, 32'h0050_0093}) begin
      errors++; $display("FAIL replay ctrl=%b imm=%h inst=%h exp addi/5/00500093", ctrl, execute_immediate_w, instruction_o);
    end
    stall_read_i = 1'b0;
  endtask

  task automatic test_exception();
    fetch(32'h0001_3083, 32'h200);  // load funct3=011: illegal
    checks++; if ({ctrl, sel, execute_immediate_w} !== {10'b1000000000, 15'd0, 32'd0}) begin
      errors++; $display("FAIL ld011 ctrl=%b sel=%h imm=%h exp illegal only", ctrl, sel, execute_immediate_w);
    end
    checks++; if (exception !== 1'b1) begin errors++; $display("FAIL ld011_exc got=%b exp=1", exception); end
    fetch(32'h0050_0093, 32'h204);
    checks++; if ({illegal_inst_w, exception} !== 2'b01) begin
      errors++; $display("FAIL exc_sticky illegal=%b exc=%b exp 0/1", illegal_inst_w, exception);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (exception !== 1'b0) begin errors++; $display("FAIL exc_clear got=%b exp=0", exception); end
    fetch(32'h0000_0000, 32'h208);
    checks++; if ({illegal_inst_w, exception, instruction_o} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL zero_word illegal=%b exc=%b inst=%h exp 1/1/0", illegal_inst_w, exception, instruction_o);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    inst_mem_is_valid = 1'b0;
    inst_mem_offset   = 2'b10;
    tick();
    checks++; if (exception !== 1'b0) begin errors++; $display("FAIL offset_invalid got=%b exp=0", exception); end
    inst_mem_is_valid  = 1'b1;
    inst_mem_read_data = 32'h0050_0093;
    tick();
    checks++; if ({exception, ctrl, instruction_o} !== {1'b1, 10'b0, 32'h13}) begin
      errors++; $display("FAIL misaligned exc=%b ctrl=%b inst=%h exp 1/0/13", exception, ctrl, instruction_o);
    end
    inst_mem_offset = 2'b00;
  endtask

  task automatic test_writeback();
    reset = 1'b1; tick(); reset = 1'b0;
    stall = 1'b1;  // writeback must not depend on stall
    wb_alu_to_reg = 1'b1; wb_dest_reg_sel = 5'd5; wb_result = 32'hDEAD_BEEF; wb_read_data = 32'h1;
    tick();
    checks++; if (dut.regs[5] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wb_alu got=%h exp=deadbeef", dut.regs[5]); end
    wb_alu_to_reg = 1'b0; wb_mem_to_reg = 1'b1; wb_dest_reg_sel = 5'd6; wb_read_data = 32'h1234_5678;
    tick();
    checks++; if (dut.regs[6] !== 32'h1234_5678) begin errors++; $display("FAIL wb_load got=%h exp=12345678", dut.regs[6]); end
    wb_dest_reg_sel = 5'd0;
    tick();
    checks++; if (dut.regs[0] !== 32'h0) begin errors++; $display("FAIL wb_x0 got=%h exp=0", dut.regs[0]); end
    wb_stall = 1'b1; wb_dest_reg_sel = 5'd7;
    tick();
    checks++; if (dut.regs[7] !== 32'h0) begin errors++; $display("FAIL wb_stalled got=%h exp=0", dut.regs[7]); end
    wb_stall = 1'b0; wb_mem_to_reg = 1'b0; wb_dest_reg_sel = 5'd8;
    tick();
    checks++; if (dut.regs[8] !== 32'h0) begin errors++; $display("FAIL wb_noenable got=%h exp=0", dut.regs[8]); end
    checks++; if (dut.regs[5] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wb_keep got=%h exp=deadbeef", dut.regs[5]); end
    stall = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; inst_mem_is_valid = 1'b0; inst_mem_read_data = '0;
    stall_read_i = 1'b0; inst_fetch_pc = '0; instruction_i = '0; wb_stall = 1'b0;
    wb_alu_to_reg = 1'b0; wb_mem_to_reg = 1'b0; wb_dest_reg_sel = '0; wb_result = '0;
    wb_read_data = '0; inst_mem_offset = '0;
    test_reset();
    test_alu();
    test_branch_store();
    test_stall_bubble();
    test_upper_replay();
    test_exception();
    test_writeback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
